sseg_scan_controller: RTL and testbench

- Time-multiplexes N_DIGITS seven-segment digits through one shared hex_to_sseg decoder instance. Drives one digit anode at a time.
- Cycles through the digits at a fixed slot rate, with a blanking guard at the start of each slot to suppress ghosting.
- New display contents are accepted through a ready/request handshake and applied only at a frame boundary, so the display never tears.
- Sits between the host register logic and the board display pins.

---
 rtl/sseg_scan_controller_pkg.sv | 15 +
 rtl/hex_to_sseg.sv | 37 +++
 rtl/sseg_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_scan_controller_pkg;

  localparam int unsigned SSEG_W   = 8;
  localparam int unsigned NIBBLE_W = 4;

  // Anodes are active-low: a 1 keeps the digit dark.
  localparam logic AN_OFF = 1'b1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low seven-segment pattern; bit 7 is the decimal point.
module hex_to_sseg
  import sseg_scan_controller_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_hex,
  input  logic                i_dp,
  output logic [SSEG_W-1:0]   o_sseg_c
);

  logic [6:0] w_seg;

  // Segment order is {g,f,e,d,c,b,a}, 0 = lit.
  always_comb begin
    w_seg = 7'h7F;
    case (i_hex)
      4'h0:    w_seg = 7'h40;
      4'h1:    w_seg = 7'h79;
      4'h2:    w_seg = 7'h24;
      4'h3:    w_seg = 7'h30;
      4'h4:    w_seg = 7'h19;
      4'h5:    w_seg = 7'h12;
      4'h6:    w_seg = 7'h02;
      4'h7:    w_seg = 7'h78;
      4'h8:    w_seg = 7'h00;
      4'h9:    w_seg = 7'h10;
      4'hA:    w_seg = 7'h08;
      4'hB:    w_seg = 7'h03;
      4'hC:    w_seg = 7'h46;
      4'hD:    w_seg = 7'h21;
      4'hE:    w_seg = 7'h06;
      4'hF:    w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
    o_sseg_c = {~i_dp, w_seg};
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// Multiplexed seven-segment scanner with blanking guard and frame-aligned,
// handshaked display updates.
module sseg_scan_controller
  import sseg_scan_controller_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  upd_req,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   en_in,
  output logic                  upd_ready,
  output logic                  upd_done,
  output logic [N_DIGITS-1:0]   an,
  output logic [SSEG_W-1:0]     sseg,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned HEX_W = NIBBLE_W * N_DIGITS;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = {N_DIGITS{AN_OFF}};
  localparam scan_state_e         ST_RESET   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  // Scan state
  scan_state_e         r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;

  // Pending (captured, not yet shown) and active (on display) contents
  logic [HEX_W-1:0]    r_pend_hex;
  logic [N_DIGITS-1:0] r_pend_dp;
  logic [N_DIGITS-1:0] r_pend_en;
  logic [HEX_W-1:0]    r_act_hex;
  logic [N_DIGITS-1:0] r_act_dp;
  logic [N_DIGITS-1:0] r_act_en;

  // Selected digit feeding the shared decoder
  logic [NIBBLE_W-1:0] r_sel_hex;
  logic                r_sel_dp;

  // Registered outputs
  logic [N_DIGITS-1:0] r_an;
  logic                r_ready;
  logic                r_done;
  logic                r_frame_start;

  // Next-state wires
  scan_state_e         w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_wrap;
  logic                w_boundary;
  logic                w_capture;
  logic                w_apply;
  logic [HEX_W-1:0]    w_act_hex_nxt;
  logic [N_DIGITS-1:0] w_act_dp_nxt;
  logic [N_DIGITS-1:0] w_act_en_nxt;
  logic [NIBBLE_W-1:0] w_sel_hex_nxt;
  logic                w_sel_dp_nxt;
  logic [N_DIGITS-1:0] w_an_nxt;
  logic                w_ready_nxt;

  // Slot counter, frame boundary and handshake decisions
  always_comb begin
    w_wrap     = (r_cnt == CNT_LAST);
    w_boundary = w_wrap && (r_idx == IDX_LAST);
    w_capture  = upd_req && r_ready;
    w_apply    = w_boundary && !r_ready;

    w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    w_act_hex_nxt = r_act_hex;
    w_act_dp_nxt  = r_act_dp;
    w_act_en_nxt  = r_act_en;
    if (w_apply) begin
      w_act_hex_nxt = r_pend_hex;
      w_act_dp_nxt  = r_pend_dp;
      w_act_en_nxt  = r_pend_en;
    end

    w_ready_nxt = r_ready;
    if (w_apply) begin
      w_ready_nxt = 1'b1;
    end else if (w_capture) begin
      w_ready_nxt = 1'b0;
    end
  end

  // Blank/show sequencing and the registered anode/segment selection
  always_comb begin
    w_state_nxt   = r_state;
    w_an_nxt      = AN_ALL_OFF;
    w_sel_hex_nxt = r_sel_hex;
    w_sel_dp_nxt  = r_sel_dp;

    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_wrap && (BLANK_CYCLES != 0)) w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_RESET;
    endcase

    if ((w_state_nxt == ST_SHOW) && w_act_en_nxt[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = ~AN_OFF;
    end

    // Load the next slot's digit so it is stable from cnt = 0.
    if (w_wrap) begin
      w_sel_hex_nxt = w_act_hex_nxt[{w_idx_nxt, 2'b00} +: NIBBLE_W];
      w_sel_dp_nxt  = w_act_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Capture port data into the pending buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_hex <= '0;
      r_pend_dp  <= '0;
      r_pend_en  <= '0;
    end else if (w_capture) begin
      r_pend_hex <= hex_in;
      r_pend_dp  <= dp_in;
      r_pend_en  <= en_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_hex <= '0;
      r_act_dp  <= '0;
      r_act_en  <= '0;
      r_sel_hex <= '0;
      r_sel_dp  <= 1'b0;
    end else begin
      r_act_hex <= w_act_hex_nxt;
      r_act_dp  <= w_act_dp_nxt;
      r_act_en  <= w_act_en_nxt;
      r_sel_hex <= w_sel_hex_nxt;
      r_sel_dp  <= w_sel_dp_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an          <= AN_ALL_OFF;
      r_ready       <= 1'b1;
      r_done        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_nxt;
      r_ready       <= w_ready_nxt;
      r_done        <= w_apply;
      r_frame_start <= w_boundary;
    end
  end

  hex_to_sseg u_hex_to_sseg (
    .i_hex    (r_sel_hex),
    .i_dp     (r_sel_dp),
    .o_sseg_c (sseg)
  );

  assign an          = r_an;
  assign upd_ready   = r_ready;
  assign upd_done    = r_done;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Scoreboard bench for sseg_scan_controller: a time-based display model
// queues per-cycle expectations, a negedge monitor compares them.
module tb_sseg_scan_controller;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        upd_req;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        upd_ready;
  logic        upd_done;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;

  always #5 clk = ~clk;

  sseg_scan_controller #(
    .N_DIGITS     (N),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd_req     (upd_req),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .en_in       (en_in),
    .upd_ready   (upd_ready),
    .upd_done    (upd_done),
    .an          (an),
    .sseg        (sseg),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ready;
    logic       done;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: cycles since reset release and the two data buffers
  int          t;
  bit          m_ready;
  bit          m_done;
  bit          m_captured;
  logic [15:0] m_pend_hex, m_act_hex;
  logic [3:0]  m_pend_dp, m_pend_en, m_act_dp, m_act_en;

  function automatic logic [6:0] seg_on(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] h, input logic dp);
    return {~dp, ~seg_on(h)};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   c;
    int   d;
    c = t % SLOT;
    d = (t / SLOT) % N;
    e.an = 4'hF;
    if (c >= BLANK && m_act_en[d]) e.an[d] = 1'b0;
    e.sseg  = decode(m_act_hex[4*d +: 4], m_act_dp[d]);
    e.ready = m_ready;
    e.done  = m_done;
    e.fs    = ((t % FRAME) == 0) && (t != 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, want);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    m_ready    = 1'b1;
    m_done     = 1'b0;
    m_captured = 1'b0;
    m_pend_hex = '0; m_pend_dp = '0; m_pend_en = '0;
    m_act_hex  = '0; m_act_dp  = '0; m_act_en  = '0;
    exp_q.delete();
    exp_q.push_back(expect_now());
  endtask

  // Drive inputs for one cycle, advance the model across the edge, queue expectations
  task automatic tick(input logic req, input logic [15:0] h, input logic [3:0] dp,
                      input logic [3:0] en);
    upd_req = req; hex_in = h; dp_in = dp; en_in = en;
    @(posedge clk);
    m_captured = 1'b0;
    m_done     = 1'b0;
    if (((t % FRAME) == FRAME - 1) && !m_ready) begin
      m_act_hex = m_pend_hex; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
      m_ready   = 1'b1;
      m_done    = 1'b1;
    end else if (req && m_ready) begin
      m_pend_hex = h; m_pend_dp = dp; m_pend_en = en;
      m_ready    = 1'b0;
      m_captured = 1'b1;
    end
    t++;
    #1;
    exp_q.push_back(expect_now());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Hold the request until the model has accepted it
  task automatic send(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] en);
    int n;
    n = 0;
    do begin
      tick(1'b1, h, dp, en);
      n++;
    end while (!m_captured && n < 200);
    checks++;
    if (!m_captured) begin
      errors++;
      $display("FAIL send_timeout got=%0d cycles expected=capture", n);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty t=%0d got=none expected=entry", t);
      end else begin
        mon_e = exp_q.pop_front();
        chk("an",          16'(an),          16'(mon_e.an));
        chk("sseg",        16'(sseg),        16'(mon_e.sseg));
        chk("upd_ready",   16'(upd_ready),   16'(mon_e.ready));
        chk("upd_done",    16'(upd_done),    16'(mon_e.done));
        chk("frame_start", 16'(frame_start), 16'(mon_e.fs));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    upd_req = 1'b0; hex_in = '0; dp_in = '0; en_in = '0;
    t = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",    16'(an),          16'hF);
    chk("rst_ready", 16'(upd_ready),   16'h1);
    chk("rst_done",  16'(upd_done),    16'h0);
    chk("rst_fs",    16'(frame_start), 16'h0);
    chk("rst_sseg",  16'(sseg),        16'(decode(4'h0, 1'b0)));

    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Idle: dark display, frame_start every frame
    idle(100);

    // First update, then a competing request held while busy
    send(16'h1A3F, 4'b0101, 4'b1111);
    send(16'hBEEF, 4'b1010, 4'b1111);
    idle(70);

    // Partial enable
    send(16'h00C4, 4'b0000, 4'b0011);
    idle(70);

    // Capture exactly on the frame boundary edge
    n = 0;
    while ((t % FRAME) != FRAME - 1 && n < 100) begin idle(1); n++; end
    tick(1'b1, 16'h5678, 4'b1000, 4'b1111);
    idle(75);

    // Random requests and data
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
    idle(70);

    // Asynchronous reset in slot 2, cnt 5
    send(16'h9876, 4'b0000, 4'b1111);
    idle(40);
    n = 0;
    while ((t % FRAME) != 2 * SLOT + 5 && n < 100) begin idle(1); n++; end
    #5;
    mon_en = 1'b0;
    exp_q.delete();
    chk("pre_reset_an", 16'(an), 16'h0B);
    reset_n = 1'b0;
    #1;
    chk("async_an",    16'(an),          16'hF);
    chk("async_ready", 16'(upd_ready),   16'h1);
    chk("async_done",  16'(upd_done),    16'h0);
    chk("async_sseg",  16'(sseg),        16'(decode(4'h0, 1'b0)));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(80);

    #6;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
